pmod_cls_multi_line_spi_solo: RTL and testbench
===============================================

# pmod_cls_multi_line_spi_solo

Parametrised PMOD CLS display driver that positions the cursor at any row/column and writes a variable-length run of characters, for displays of `parm_num_lines` rows by `parm_line_chars` columns. It sits between the system FSM and `pmod_generic_spi_solo`, loading escape sequences and text into the SPI TX FIFO and launching SPI Mode 0 transfers. Beyond the fixed-line two-row CLS driver, it adds partial-line updates, runtime row/column selection, and command validation with an error pulse.

## Interface
- `parm_fast_simulation`, default 0: 1 selects a 2 ms boot wait; 0 selects 800 ms.
- `FCLK_ce`, default 2500000: rate in Hz of `i_spi_ce_4x`.
- `parm_num_lines`, default 2: display rows, range 1..4.
- `parm_line_chars`, default 16: columns, range 1..40.
- `parm_tx_len_bits`, default 11; `parm_wait_cyc_bits`, default 2; `parm_rx_len_bits`, default 11: widths of the generic SPI length fields.

Ports:
- `i_ext_spi_clk_x`  in  1  sole clock.
- `i_srst`  in  1  asynchronous, active-high reset.
- `i_spi_ce_4x`  in  1  clock enable; all state, timer and aux updates occur only on enabled cycles.
- `o_go_stand`  out  1  start SPI transfer.
- `i_spi_idle`  in  1  SPI idle.
- `o_tx_len`  out  `parm_tx_len_bits`  TX byte count.
- `o_wait_cyc`  out  `parm_wait_cyc_bits`  tied 0.
- `o_rx_len`  out  `parm_rx_len_bits`  tied 0.
- `o_tx_data`  out  8  FIFO byte.
- `o_tx_enqueue`  out  1  FIFO write.
- `i_tx_ready`  in  1  FIFO can accept.
- `i_rx_data`  in  8  unused.
- `i_rx_valid`  in  1  unused.
- `i_rx_avail`  in  1  unused.
- `o_rx_dequeue`  out  1  tied 0.
- `o_command_ready`  out  1  high in IDLE only.
- `i_cmd_wr_clear_display`  in  1  clear request.
- `i_cmd_wr_text`  in  1  text request.
- `i_cmd_row`  in  2  target row.
- `i_cmd_col`  in  6  start column.
- `i_cmd_len`  in  6  character count.
- `i_dat_ascii`  in  `8*parm_line_chars`  full-line image; char 0 occupies the MSBs.
- `o_cmd_error`  out  1  one-tick rejection pulse.

## Operation
- States:
  - BOOT: waits `c_boot` ticks, where `c_boot = FCLK_ce/1000*(fast?2:800)`. Moves to IDLE when the timer equals `c_boot-1`.
  - IDLE: asserts `o_command_ready`. Clear takes priority over text.
  - LOAD_CLEAR: loads the 4-byte command `1B 5B 30 6A` and sets the data length to 0.
  - VALIDATE: checks the latched text command.
    - Error if `row >= parm_num_lines`, `len == 0`, or `col+len > parm_line_chars`. The sum is computed 7 bits wide.
    - On error, goes to ERR. Otherwise goes to LOAD_TEXT.
  - ERR: `o_cmd_error` = 1 for one tick, then IDLE.
  - LOAD_TEXT: loads the 7-byte command `1B 5B ('0'+row) 3B ('0'+col/10) ('0'+col%10) 48` and the data bytes chars `col..col+len-1`.
  - CMD_RUN: enqueues one command byte on each tick where `i_tx_ready=1`.
    - `o_tx_len` equals the command length.
    - `o_go_stand` asserts on the same tick as the last enqueue.
  - CMD_WAIT: on `i_spi_idle=1`, goes to DAT_RUN if the data length is > 0, else to IDLE.
  - DAT_RUN: same as CMD_RUN for the data bytes, with `o_tx_len` = len.
  - DAT_WAIT: returns to IDLE on `i_spi_idle=1`.
- Row, col, len and the line image are latched on the acceptance tick. Input changes after acceptance have no effect.
- Divide-by-10 is a constant lookup over 0..39.
- Inputs in BOOT and in busy states are ignored; there is no queuing.
- The timer clears on every state change and saturates at `c_boot-1`.

## Timing
- Reset (async):
  - State goes to BOOT; timer and all aux registers go to 0.
  - All outputs are 0 during reset and BOOT.
- All latencies below are in enabled ticks.
- Accept to first enqueue: 2 ticks for clear (IDLE, LOAD_CLEAR, CMD_RUN); 3 ticks for text (adds VALIDATE).
- With `i_tx_ready` constantly high, an n-byte run takes n ticks. A low `i_tx_ready` stalls the run with `o_tx_enqueue=0` and the byte held.
- Contract: the generic SPI drops `i_spi_idle` on the tick following `o_go_stand`. WAIT states therefore sample idle no earlier than one tick after go.
- Reset mid-transfer aborts at once: no further enqueue, and the full boot wait is repeated.
- Clear and text asserted together: clear is serviced and the text request is dropped.

## Test plan
- **Boot:** fast sim, `FCLK_ce` = 2.5 MHz → `o_command_ready` rises exactly 5000 ticks after reset release.
- **Clear:** bytes `1B 5B 30 6A` are enqueued, `o_tx_len`=4, and `o_go_stand` coincides with `6A`. With `i_spi_idle` returning, the block is back in IDLE with no data phase.
- **Full line:** row 1, col 0, len 16, line `"ABCDEFGHIJKLMNOP"` → `1B 5B 31 3B 30 30 48`, go, wait, then `41..50` with `o_tx_len`=16 and go on `50`.
- **Partial:** row 0, col 12, len 4 → `1B 5B 30 3B 31 32 48`, then chars 12..15 (`4D 4E 4F 50`).
- **Errors:** with `parm_num_lines`=2, row 2 → one `o_cmd_error` pulse and no enqueue. col 14 + len 3 → error. len 0 → error. Each returns to IDLE.
- **Backpressure/reset:** toggling `i_tx_ready` gives byte order unchanged with no duplicates. Asserting `i_srst` mid DAT_RUN → outputs go to 0 immediately, and `o_command_ready` returns after a full boot wait.

Source files
------------

// File: rtl/pmod_cls_multi_line_spi_solo.sv
// pmod_cls_multi_line_spi_solo
// Drives a PMOD CLS character display through pmod_generic_spi_solo.
// The display has parm_num_lines rows of parm_line_chars columns.
// A command either clears the display or writes a run of characters at
// a chosen row/column. A text command that does not fit the display is
// rejected with a one-tick o_cmd_error pulse.
// Ports:
//   i_ext_spi_clk_x / i_srst  : clock, asynchronous active-high reset
//   i_spi_ce_4x               : clock enable; all state moves on enabled ticks
//   o_go_stand, i_spi_idle    : SPI transfer launch / SPI idle status
//   o_tx_len, o_tx_data, o_tx_enqueue, i_tx_ready : SPI TX FIFO side
//   o_wait_cyc, o_rx_len, o_rx_dequeue, i_rx_*    : unused receive side
//   o_command_ready           : high while idle and able to accept a command
//   i_cmd_wr_clear_display / i_cmd_wr_text : requests; clear has priority
//   i_cmd_row/col/len, i_dat_ascii (char 0 in MSBs), o_cmd_error
module pmod_cls_multi_line_spi_solo #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_num_lines       = 2,
  parameter int parm_line_chars      = 16,
  parameter int parm_tx_len_bits     = 11,
  parameter int parm_wait_cyc_bits   = 2,
  parameter int parm_rx_len_bits     = 11
) (
  input  logic                          i_ext_spi_clk_x,
  input  logic                          i_srst,
  input  logic                          i_spi_ce_4x,
  output logic                          o_go_stand,
  input  logic                          i_spi_idle,
  output logic [parm_tx_len_bits-1:0]   o_tx_len,
  output logic [parm_wait_cyc_bits-1:0] o_wait_cyc,
  output logic [parm_rx_len_bits-1:0]   o_rx_len,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_enqueue,
  input  logic                          i_tx_ready,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_avail,
  output logic                          o_rx_dequeue,
  output logic                          o_command_ready,
  input  logic                          i_cmd_wr_clear_display,
  input  logic                          i_cmd_wr_text,
  input  logic [1:0]                    i_cmd_row,
  input  logic [5:0]                    i_cmd_col,
  input  logic [5:0]                    i_cmd_len,
  input  logic [8*parm_line_chars-1:0]  i_dat_ascii,
  output logic                          o_cmd_error
);

  localparam int c_boot     = FCLK_ce / 1000 * ((parm_fast_simulation != 0) ? 2 : 800);
  localparam int c_tmr_bits = (c_boot > 2) ? $clog2(c_boot) : 1;
  localparam logic [c_tmr_bits-1:0] c_tmr_max = c_tmr_bits'(c_boot - 1);

  localparam logic [3:0] ST_BOOT       = 4'd0;
  localparam logic [3:0] ST_IDLE       = 4'd1;
  localparam logic [3:0] ST_LOAD_CLEAR = 4'd2;
  localparam logic [3:0] ST_VALIDATE   = 4'd3;
  localparam logic [3:0] ST_ERR        = 4'd4;
  localparam logic [3:0] ST_LOAD_TEXT  = 4'd5;
  localparam logic [3:0] ST_CMD_RUN    = 4'd6;
  localparam logic [3:0] ST_CMD_WAIT   = 4'd7;
  localparam logic [3:0] ST_DAT_RUN    = 4'd8;
  localparam logic [3:0] ST_DAT_WAIT   = 4'd9;

  logic [3:0]                   state_reg, state_next;
  logic [c_tmr_bits-1:0]        timer_reg;
  logic [1:0]                   row_reg;
  logic [5:0]                   col_reg, len_reg;
  logic [8*parm_line_chars-1:0] line_reg;
  logic [7:0]                   cmd_buf_reg [7];
  logic [2:0]                   cmd_len_reg;
  logic [5:0]                   dat_len_reg;
  logic [5:0]                   idx_reg;

  // Constant divide-by-10 table for the column digits (columns 0..39).
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    tens_of = 4'd0;
    case (v) inside
      [6'd10:6'd19]: tens_of = 4'd1;
      [6'd20:6'd29]: tens_of = 4'd2;
      [6'd30:6'd39]: tens_of = 4'd3;
      default:       tens_of = 4'd0;
    endcase
  endfunction

  logic [3:0] col_tens;
  logic [5:0] col_ones;
  assign col_tens = tens_of(col_reg);
  assign col_ones = col_reg - (6'(col_tens) * 6'd10);

  // The sum is one bit wider than the operands so a 6-bit wrap cannot hide
  // an overlong run.
  logic [6:0] col_plus_len;
  logic       cmd_bad;
  assign col_plus_len = {1'b0, col_reg} + {1'b0, len_reg};
  assign cmd_bad = ({5'd0, row_reg} >= 7'(parm_num_lines)) ||
                   (len_reg == 6'd0) ||
                   (col_plus_len > 7'(parm_line_chars));

  // Split the latched line image into characters, char 0 from the MSBs.
  logic [7:0] line_char [parm_line_chars];
  genvar gi;
  generate
    for (gi = 0; gi < parm_line_chars; gi++) begin : g_char
      assign line_char[gi] = line_reg[8*(parm_line_chars-1-gi) +: 8];
    end
  endgenerate

  logic [5:0] dat_idx;
  logic [7:0] dat_byte;
  assign dat_idx = col_reg + idx_reg;
  always_comb begin
    dat_byte = 8'h00;
    for (int i = 0; i < parm_line_chars; i++) begin
      if (dat_idx == 6'(i)) dat_byte = line_char[i];
    end
  end

  logic in_cmd_run, in_dat_run, run_last, enq;
  assign in_cmd_run = (state_reg == ST_CMD_RUN);
  assign in_dat_run = (state_reg == ST_DAT_RUN);
  assign run_last   = in_cmd_run ? (idx_reg == ({3'd0, cmd_len_reg} - 6'd1))
                                 : (idx_reg == (dat_len_reg - 6'd1));
  assign enq        = (in_cmd_run || in_dat_run) && i_spi_ce_4x && i_tx_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT:       if (timer_reg == c_tmr_max) state_next = ST_IDLE;
      ST_IDLE:       if (i_cmd_wr_clear_display) state_next = ST_LOAD_CLEAR;
                     else if (i_cmd_wr_text)     state_next = ST_VALIDATE;
      ST_LOAD_CLEAR: state_next = ST_CMD_RUN;
      ST_VALIDATE:   state_next = cmd_bad ? ST_ERR : ST_LOAD_TEXT;
      ST_ERR:        state_next = ST_IDLE;
      ST_LOAD_TEXT:  state_next = ST_CMD_RUN;
      ST_CMD_RUN:    if (i_tx_ready && run_last) state_next = ST_CMD_WAIT;
      ST_CMD_WAIT:   if (i_spi_idle)
                       state_next = (dat_len_reg != 6'd0) ? ST_DAT_RUN : ST_IDLE;
      ST_DAT_RUN:    if (i_tx_ready && run_last) state_next = ST_DAT_WAIT;
      ST_DAT_WAIT:   if (i_spi_idle) state_next = ST_IDLE;
      default:       state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      state_reg   <= ST_BOOT;
      timer_reg   <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      len_reg     <= '0;
      line_reg    <= '0;
      cmd_len_reg <= '0;
      dat_len_reg <= '0;
      idx_reg     <= '0;
      for (int i = 0; i < 7; i++) cmd_buf_reg[i] <= 8'h00;
    end else if (i_spi_ce_4x) begin
      state_reg <= state_next;
      if (state_next != state_reg)  timer_reg <= '0;
      else if (timer_reg != c_tmr_max) timer_reg <= timer_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          // Latch operands only when text is the request actually serviced.
          if (!i_cmd_wr_clear_display && i_cmd_wr_text) begin
            row_reg  <= i_cmd_row;
            col_reg  <= i_cmd_col;
            len_reg  <= i_cmd_len;
            line_reg <= i_dat_ascii;
          end
        end
        ST_LOAD_CLEAR: begin
          cmd_buf_reg[0] <= 8'h1B;
          cmd_buf_reg[1] <= 8'h5B;
          cmd_buf_reg[2] <= 8'h30;
          cmd_buf_reg[3] <= 8'h6A;
          cmd_len_reg    <= 3'd4;
          dat_len_reg    <= 6'd0;
          idx_reg        <= 6'd0;
        end
        ST_LOAD_TEXT: begin
          cmd_buf_reg[0] <= 8'h1B;
          cmd_buf_reg[1] <= 8'h5B;
          cmd_buf_reg[2] <= 8'h30 + {6'd0, row_reg};
          cmd_buf_reg[3] <= 8'h3B;
          cmd_buf_reg[4] <= 8'h30 + {4'd0, col_tens};
          cmd_buf_reg[5] <= 8'h30 + {2'd0, col_ones};
          cmd_buf_reg[6] <= 8'h48;
          cmd_len_reg    <= 3'd7;
          dat_len_reg    <= len_reg;
          idx_reg        <= 6'd0;
        end
        ST_CMD_RUN, ST_DAT_RUN: begin
          if (i_tx_ready) idx_reg <= run_last ? 6'd0 : idx_reg + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_tx_enqueue    = enq;
  assign o_go_stand      = enq && run_last;
  assign o_tx_data       = in_cmd_run ? cmd_buf_reg[idx_reg[2:0]] :
                           in_dat_run ? dat_byte : 8'h00;
  assign o_tx_len        = in_cmd_run ? parm_tx_len_bits'(cmd_len_reg) :
                           in_dat_run ? parm_tx_len_bits'(dat_len_reg) : '0;
  assign o_command_ready = (state_reg == ST_IDLE);
  assign o_cmd_error     = (state_reg == ST_ERR) && i_spi_ce_4x;
  assign o_wait_cyc      = '0;
  assign o_rx_len        = '0;
  assign o_rx_dequeue    = 1'b0;

  logic unused_rx;
  assign unused_rx = ^{i_rx_data, i_rx_valid, i_rx_avail};

endmodule

// File: tb/tb_pmod_cls_multi_line_spi_solo.sv
// Scoreboard bench for pmod_cls_multi_line_spi_solo (fast boot, 2 x 16 display).
module tb_pmod_cls_multi_line_spi_solo;

  logic         clk = 1'b0, srst = 1'b1, ce = 1'b0;
  logic         spi_idle = 1'b1, tx_ready = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0, rx_avail = 1'b0;
  logic         clr = 1'b0, txt = 1'b0;
  logic [1:0]   row = 2'd0;
  logic [5:0]   col = 6'd0, len = 6'd0;
  logic [127:0] ascii = '0;

  logic         go, enq, rx_deq, ready, err;
  logic [10:0]  tx_len, rx_len;
  logic [1:0]   wait_cyc;
  logic [7:0]   tx_data;

  pmod_cls_multi_line_spi_solo #(
    .parm_fast_simulation(1), .FCLK_ce(2500000), .parm_num_lines(2),
    .parm_line_chars(16), .parm_tx_len_bits(11), .parm_wait_cyc_bits(2),
    .parm_rx_len_bits(11)
  ) dut (
    .i_ext_spi_clk_x(clk), .i_srst(srst), .i_spi_ce_4x(ce),
    .o_go_stand(go), .i_spi_idle(spi_idle), .o_tx_len(tx_len),
    .o_wait_cyc(wait_cyc), .o_rx_len(rx_len), .o_tx_data(tx_data),
    .o_tx_enqueue(enq), .i_tx_ready(tx_ready), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .i_rx_avail(rx_avail), .o_rx_dequeue(rx_deq),
    .o_command_ready(ready), .i_cmd_wr_clear_display(clr),
    .i_cmd_wr_text(txt), .i_cmd_row(row), .i_cmd_col(col),
    .i_cmd_len(len), .i_dat_ascii(ascii), .o_cmd_error(err)
  );

  typedef struct {
    bit         is_err;
    bit         go;
    int         len;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;
  bit   bp_en    = 1'b0;

  localparam logic [127:0] LINE = "ABCDEFGHIJKLMNOP";

  always #5 clk = ~clk;

  // Clock enable every other cycle; it changes 2 time units after a rising
  // edge so it is stable at both the sampling negedge and the next posedge.
  initial forever begin
    @(posedge clk);
    #2 ce = ~ce;
  end

  // Backpressure pattern applied just after each rising edge.
  initial begin : bp_drv
    logic [7:0] pat;
    int         k;
    pat = 8'b1011_0010;
    k   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        tx_ready = pat[k%8];
        k++;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Generic SPI model: drops idle right after go, busy for 4 ticks.
  initial begin : spi_model
    int busy;
    busy = 0;
    forever begin
      @(negedge clk);
      if (srst) begin
        spi_idle = 1'b1;
        busy = 0;
      end else if (ce) begin
        if (go) begin
          spi_idle = 1'b0;
          busy = 4;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) spi_idle = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per enqueue or error pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!srst && ce && (enq || err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {err, go, tx_len, tx_data}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          n_pops++;
          $display("txn %s data=%02h go=%0b len=%0d", err ? "err" : "byte", tx_data, go, tx_len);
          check("txn", {err, enq, go, tx_len, tx_data},
                {e.is_err, !e.is_err, e.go, 11'(e.len), e.data});
        end
      end
      if (!srst && go && !enq) check("go_without_enqueue", {go, enq}, 64'h0);
    end
  end

  task automatic tick();
    do @(posedge clk); while (!ce);
    #1;
  endtask

  task automatic push_bytes(input logic [319:0] v, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{is_err: 1'b0, go: (k == n-1), len: n, data: v[8*(n-1-k) +: 8]});
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, go: 1'b0, len: 0, data: 8'h00});
  endtask

  // Presents one request for a single accepting tick, then scrambles the
  // operands so that only latched values can produce the expected bytes.
  task automatic issue(input bit c, input bit t, input logic [1:0] r,
                       input logic [5:0] cl, input logic [5:0] ln, input logic [127:0] a);
    int g;
    g = 0;
    while (!ready && g < 20000) begin tick(); g++; end
    if (!ready) check("issue_ready_timeout", {63'd0, ready}, 64'd1);
    clr = c; txt = t; row = r; col = cl; len = ln; ascii = a;
    tick();
    clr = 1'b0; txt = 1'b0; row = 2'd3; col = 6'd63; len = 6'd63; ascii = ~a;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (!ready && g < 3000) begin tick(); g++; end
    check(name, {ready, 32'(exp_q.size())}, {1'b1, 32'd0});
  endtask

  task automatic boot_check(input string name);
    for (int k = 1; k <= 5000; k++) begin
      tick();
      if (k == 1)    check({name, "_boot_outputs"}, {go, enq, tx_len, tx_data, ready, err}, 64'h0);
      if (k == 4999) check({name, "_not_ready_4999"}, {63'd0, ready}, 64'd0);
      if (k == 5000) check({name, "_ready_5000"}, {63'd0, ready}, 64'd1);
    end
  endtask

  initial begin
    int g, base;
    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs",
          {go, enq, tx_len, tx_data, ready, err, wait_cyc, rx_len, rx_deq}, 64'h0);
    srst = 1'b0;
    boot_check("boot1");

    // Clear: LOAD_CLEAR on the tick after accept, CMD_RUN on the next
    push_bytes(320'h1B5B306A, 4);
    issue(1'b1, 1'b0, 2'd0, 6'd0, 6'd0, LINE);
    check("clear_lat_load", {53'd0, tx_len}, 64'd0);
    tick();
    check("clear_lat_run", {53'd0, tx_len}, 64'd4);
    wait_done("clear_done");

    // Full line, with latency of VALIDATE + LOAD_TEXT
    push_bytes(320'h1B5B313B303048, 7);
    push_bytes(320'h4142434445464748494A4B4C4D4E4F50, 16);
    issue(1'b0, 1'b1, 2'd1, 6'd0, 6'd16, LINE);
    tick();
    check("text_lat_load", {53'd0, tx_len}, 64'd0);
    tick();
    check("text_lat_run", {53'd0, tx_len}, 64'd7);
    wait_done("full_line_done");

    // Partial updates
    push_bytes(320'h1B5B303B313248, 7);
    push_bytes(320'h4D4E4F50, 4);
    issue(1'b0, 1'b1, 2'd0, 6'd12, 6'd4, LINE);
    wait_done("partial_12_4");

    push_bytes(320'h1B5B313B303548, 7);
    push_bytes(320'h464748, 3);
    issue(1'b0, 1'b1, 2'd1, 6'd5, 6'd3, LINE);
    wait_done("partial_5_3");

    push_bytes(320'h1B5B303B313548, 7);
    push_bytes(320'h50, 1);
    issue(1'b0, 1'b1, 2'd0, 6'd15, 6'd1, LINE);
    wait_done("last_column");

    push_bytes(320'h1B5B313B313048, 7);
    push_bytes(320'h4B4C, 2);
    issue(1'b0, 1'b1, 2'd1, 6'd10, 6'd2, LINE);
    wait_done("col_10");

    // Rejections
    push_err();
    issue(1'b0, 1'b1, 2'd2, 6'd0, 6'd1, LINE);
    wait_done("err_row");
    push_err();
    issue(1'b0, 1'b1, 2'd0, 6'd14, 6'd3, LINE);
    wait_done("err_overrun");
    push_err();
    issue(1'b0, 1'b1, 2'd0, 6'd0, 6'd0, LINE);
    wait_done("err_len0");

    // Clear and text together: only the clear is serviced
    push_bytes(320'h1B5B306A, 4);
    issue(1'b1, 1'b1, 2'd1, 6'd0, 6'd4, LINE);
    wait_done("clear_priority");

    // Backpressure
    bp_en = 1'b1;
    push_bytes(320'h1B5B303B303048, 7);
    push_bytes(320'h4142434445464748494A4B4C4D4E4F50, 16);
    issue(1'b0, 1'b1, 2'd0, 6'd0, 6'd16, LINE);
    wait_done("backpressure");
    bp_en = 1'b0;

    // Reset in the middle of the data run
    base = n_pops;
    push_bytes(320'h1B5B313B303048, 7);
    push_bytes(320'h4142434445464748494A4B4C4D4E4F50, 16);
    issue(1'b0, 1'b1, 2'd1, 6'd0, 6'd16, LINE);
    g = 0;
    while (n_pops < base + 10 && g < 500) begin tick(); g++; end
    check("mid_data_run", {53'd0, tx_len}, 64'd16);
    srst = 1'b1;
    #1;
    check("reset_abort_outputs", {go, enq, tx_len, tx_data, ready, err}, 64'h0);
    exp_q.delete();
    repeat (3) tick();
    srst = 1'b0;
    boot_check("boot2");

    push_bytes(320'h1B5B306A, 4);
    issue(1'b1, 1'b0, 2'd0, 6'd0, 6'd0, LINE);
    wait_done("clear_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
